// File: rtl/alu_pkg.sv
// Shared ALU operation codes, FSM encoding and shift helpers for the execute stage.
// The control decoder imports these same codes.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SRL   = 4'b0011;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_PASSB = 4'b1011;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_kind_e;

  function automatic logic is_shift(input logic [3:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

  function automatic shift_kind_e shift_kind(input logic [3:0] ctl);
    case (ctl)
      ALU_SRL: return SH_RL;
      ALU_SRA: return SH_RA;
      default: return SH_LL;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Operand/result handshake bundle between the ID/EX registers, the ALU and EX/MEM.
interface alu_seq_exec_if #(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output flush, in_valid, alu_ctl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  flush, in_valid, alu_ctl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath and illegal-code detection.
// Shift codes pass op_a through, which is the correct result for a zero shift amount.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y,
  output logic            illegal
);

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (ctl)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:   y = a ^ b;
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      ALU_SLL, ALU_SRL, ALU_SRA: y = a;
      default: begin
        y       = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic ops, bit-serial shifter, registered result.
//
// state   | meaning
// S_IDLE  | empty, ready to accept
// S_SHIFT | serial shift in progress, cnt = remaining steps
// S_DONE  | result held on out_valid until out_ready
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_exec_if.slave bus
);

  logic [1:0]         state;
  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] cnt;
  shift_kind_e        kind;
  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic               illegal_q;

  logic [XLEN-1:0]    comb_y;
  logic               comb_ill;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               in_shift;
  logic [XLEN-1:0]    first_step;
  logic [XLEN-1:0]    acc_step;

  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input shift_kind_e k);
    case (k)
      SH_RL:   return {1'b0, v[XLEN-1:1]};
      SH_RA:   return {v[XLEN-1], v[XLEN-1:1]};
      default: return {v[XLEN-2:0], 1'b0};
    endcase
  endfunction

  alu_comb #(.XLEN(XLEN)) u_comb (
    .ctl     (bus.alu_ctl),
    .a       (bus.op_a),
    .b       (bus.op_b),
    .y       (comb_y),
    .illegal (comb_ill)
  );

  assign shamt      = bus.op_b[SHAMT_W-1:0];
  assign in_shift   = is_shift(bus.alu_ctl);
  assign first_step = shift1(bus.op_a, shift_kind(bus.alu_ctl));
  assign acc_step   = shift1(acc, kind);

  assign bus.in_ready  = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  // Flush outranks the handshake, so a flushed input is never consumed.
  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      kind      <= SH_LL;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result_q  <= acc_step;
            zero_q    <= (acc_step == '0);
            illegal_q <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            if (in_shift && (shamt != '0)) begin
              acc       <= first_step;
              cnt       <= shamt - SHAMT_W'(1);
              kind      <= shift_kind(bus.alu_ctl);
              illegal_q <= 1'b0;
              if (shamt == SHAMT_W'(1)) begin
                result_q <= first_step;
                zero_q   <= (first_step == '0);
                state    <= S_DONE;
              end else begin
                state <= S_SHIFT;
              end
            end else begin
              result_q  <= comb_y;
              zero_q    <= (comb_y == '0);
              illegal_q <= comb_ill;
              state     <= S_DONE;
            end
          end else if ((state != S_DONE) || bus.out_ready) begin
            // Also recovers the unused encoding back to idle.
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: driver pushes model results, monitor pops on output handshakes.
module tb_alu_seq_exec;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_exec_if #(.XLEN(32)) bus ();
  alu_seq_exec #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ordy_prob = 100;
  bit   seen_cur = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the operation table.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    sh = int'(b[4:0]);
    e.ill = 1'b0;
    e.lat = 1;
    e.acc_cyc = 0;
    case (c)
      4'b0000: e.res = a + b;
      4'b0001: e.res = a - b;
      4'b0010: begin e.res = a << sh; e.lat = (sh == 0) ? 1 : sh; end
      4'b0011: begin e.res = a >> sh; e.lat = (sh == 0) ? 1 : sh; end
      4'b1000: begin e.res = 32'($signed(a) >>> sh); e.lat = (sh == 0) ? 1 : sh; end
      4'b1001: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: e.res = (a < b) ? 32'd1 : 32'd0;
      4'b0111: e.res = a ^ b;
      4'b0110: e.res = a | b;
      4'b0101: e.res = a & b;
      4'b1011: e.res = b;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic pick_ready();
    return ($urandom_range(99) < ordy_prob);
  endfunction

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int waited);
    exp_t e;
    e = model(c, a, b);
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.flush     = 1'b0;
      bus.alu_ctl   = c;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.out_ready = pick_ready();
      #1;
      if (bus.in_ready) begin
        e.acc_cyc = cyc;
        sb.push_back(e);
        return;
      end
      waited++;
    end
    n_cmp++;
    n_err++;
    $display("FAIL issue_timeout: in_ready never high, ctl=%b", c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.alu_ctl   = 4'($urandom);
      bus.op_a      = $urandom;
      bus.op_b      = $urandom;
      bus.out_ready = pick_ready();
    end
  endtask

  task automatic drain();
    ordy_prob = 100;
    for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, wanted 0", sb.size());
    end
    idle(1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_result"},    bus.result,         32'd0);
    chk({tag, "_zero"},      32'(bus.zero),      32'd1);
    chk({tag, "_illegal"},   32'(bus.illegal),   32'd0);
  endtask

  // Monitor: latency on first sight of a result, fields on handshake.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out_valid: got result 0x%08h with nothing outstanding", bus.result);
        end else begin
          if (!seen_cur) begin
            chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            seen_cur = 1'b1;
          end
          if (bus.out_ready) begin
            e = sb.pop_front();
            chk("result",  bus.result,         e.res);
            chk("zero",    32'(bus.zero),      32'(e.z));
            chk("illegal", 32'(bus.illegal),   32'(e.ill));
            seen_cur = 1'b0;
          end
        end
      end
    end
  end

  logic [3:0] codes [11] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT,
                             ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_PASSB};

  initial begin
    int w;
    logic [3:0]  c;
    logic [31:0] a, b;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.alu_ctl = 4'd0;
    bus.op_a = 32'd0; bus.op_b = 32'd0; bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_state("por");

    // Reset in the middle of a long shift.
    ordy_prob = 100;
    issue(ALU_SLL, 32'd1, 32'd20, w);
    idle(4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    seen_cur = 1'b0;
    #1;
    chk_reset_state("midshift_rst");

    // ADD/SUB wrap, back to back.
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, w);
    issue(ALU_SUB, 32'd0, 32'd1, w);
    chk("sub_no_bubble_wait", 32'(w), 32'd0);
    drain();

    // SRA by 31: busy for cycles 1..30, valid at 31.
    issue(ALU_SRA, 32'h8000_0000, 32'd31, w);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("sra_busy_in_ready", 32'(bus.in_ready), 32'd0);
    end
    drain();

    issue(ALU_SRL, 32'hA5A5_0F0F, 32'h0000_0020, w);
    issue(ALU_SLL, 32'h4000_0001, 32'd1, w);
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, w);
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, w);
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, w);
    drain();

    // Backpressure hold, then flush with a competing input.
    ordy_prob = 0;
    issue(ALU_PASSB, 32'hCAFE_0000, 32'h1234_5000, w);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.alu_ctl   = ALU_ADD;
      bus.op_a      = $urandom;
      bus.op_b      = $urandom;
      bus.out_ready = 1'b0;
      #1;
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result",    bus.result,         32'h1234_5000);
      chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_ctl   = ALU_PASSB;
    bus.op_b      = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("flush_not_consumed", 32'(bus.out_valid), 32'd0);
    sb.delete();
    seen_cur = 1'b0;

    // Randomized traffic with backpressure.
    ordy_prob = 70;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(9) == 0) c = 4'($urandom);
      else c = codes[$urandom_range(10)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(7) == 0) a = 32'h8000_0000;
      if ($urandom_range(7) == 0) b = a;
      issue(c, a, b, w);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
